truth_table_sweep: RTL and testbench

Hardware stimulus-and-check engine for small combinational blocks in the lab designs. It drives every input vector of an N_IN-input DUT in ascending order and holds each vector for HOLD clock cycles. At the end of each hold it samples the DUT outputs and compares them against a parameterised expected truth table. It reports mismatch counts and the first failing vector, and supports single-pass or continuous looping, so an exhaustive bench can run on the board.

---
 rtl/sweep_pkg.sv | 32 +++
 rtl/sweep_hold_timer.sv | 34 +++
 rtl/truth_table_sweep.sv | 162 ++++++++++++++++
 tb/tb_truth_table_sweep.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth-table sweep engine.
package sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int TBL_AW  = 10;
    localparam int TBL_MAX = 1 << TBL_AW;
    localparam int OUT_MAX = 16;

    // Entry for vector v: tbl[v*n_out +: n_out], zero-padded to OUT_MAX.
    function automatic logic [OUT_MAX-1:0] exp_entry(
        input logic [TBL_MAX-1:0] tbl,
        input int                 v,
        input int                 n_out
    );
        logic [OUT_MAX-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < OUT_MAX; i++) begin
            idx = v * n_out + i;
            if (i < n_out && idx < TBL_MAX) begin
                r[i] = tbl[idx[TBL_AW-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold-period counter: counts 0..HOLD-1 while not cleared, ticks on the last count.
module sweep_hold_timer #(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Exhaustive stimulus/check engine: walks all input vectors and
// compares the DUT response against a packed expected truth table.
module truth_table_sweep
    import sweep_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int HOLD  = 10,
    parameter int ERR_W = 8,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'b1110_1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             loop_en,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             sample_valid,
    output logic             mismatch,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);

    localparam logic [TBL_MAX-1:0] TBL = TBL_MAX'(EXPECTED);

    state_e state_q, state_d;

    logic [N_IN-1:0]  stim_q, stim_d;
    logic             sv_q, sv_d;
    logic             mm_q, mm_d;
    logic             done_q, done_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fev_q, fev_d;
    logic             fevld_q, fevld_d;

    logic               tick;
    logic               tmr_clr;
    logic               start_go;
    logic               last_vec;
    logic               cmp_mm;
    logic [OUT_MAX-1:0] exp_full;

    assign start_go = start && (state_q != S_RUN);
    assign tmr_clr  = (state_q != S_RUN);
    assign last_vec = (stim_q == '1);

    sweep_hold_timer #(
        .HOLD (HOLD)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .tick (tick)
    );

    always_comb begin
        exp_full = exp_entry(TBL, int'(stim_q), N_OUT);
    end

    assign cmp_mm = (dut_out != exp_full[N_OUT-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tick && last_vec && !loop_en) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stim_d  = stim_q;
        sv_d    = 1'b0;
        mm_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevld_d = fevld_q;
        if (start_go) begin
            stim_d  = '0;
            done_d  = 1'b0;
            err_d   = '0;
            fev_d   = '0;
            fevld_d = 1'b0;
        end else if (state_q == S_RUN) begin
            done_d = 1'b0;
            if (tick) begin
                sv_d = 1'b1;
                mm_d = cmp_mm;
                if (cmp_mm) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fevld_q) begin
                        fev_d   = stim_q;
                        fevld_d = 1'b1;
                    end
                end
                // Last vector: wrap when looping, otherwise park on it.
                if (last_vec) begin
                    done_d = 1'b1;
                    stim_d = loop_en ? '0 : stim_q;
                end else begin
                    stim_d = stim_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_q  <= '0;
            sv_q    <= 1'b0;
            mm_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fevld_q <= 1'b0;
        end else begin
            stim_q  <= stim_d;
            sv_q    <= sv_d;
            mm_q    <= mm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevld_q <= fevld_d;
        end
    end

    always_comb begin
        stim            = stim_q;
        busy            = (state_q == S_RUN);
        sample_valid    = sv_q;
        mismatch        = mm_q;
        done            = done_q;
        pass            = done_q && (err_q == '0);
        err_count       = err_q;
        first_err_vec   = fev_q;
        first_err_valid = fevld_q;
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Self-checking bench for truth_table_sweep across three parameter sets.
module tb_truth_table_sweep;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mk_xor_tbl();
        logic [31:0] t;
        t = '0;
        for (int v = 0; v < 16; v++) begin
            t[v*2 +: 2] = 2'((v % 4) ^ (v / 4));
        end
        return t;
    endfunction

    localparam logic [31:0] TBL_C = mk_xor_tbl();

    function automatic logic maj(input int v);
        return (((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)) >= 2);
    endfunction

    // Instance A: defaults
    logic       start_a, loop_a;
    logic [7:0] resp_a;
    logic [0:0] dout_a;
    logic [2:0] stim_a, fev_a;
    logic [7:0] err_a;
    logic       busy_a, sv_a, mm_a, done_a, pass_a, fevld_a;
    assign dout_a[0] = resp_a[stim_a];

    truth_table_sweep u_a (
        .clk(clk), .rst(rst), .start(start_a), .loop_en(loop_a),
        .dut_out(dout_a), .stim(stim_a), .busy(busy_a),
        .sample_valid(sv_a), .mismatch(mm_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_vec(fev_a),
        .first_err_valid(fevld_a)
    );

    // Instance B: 2-bit saturating counter, AND-gate faulty DUT
    logic       start_b, loop_b;
    logic [0:0] dout_b;
    logic [2:0] stim_b, fev_b;
    logic [1:0] err_b;
    logic       busy_b, sv_b, mm_b, done_b, pass_b, fevld_b;
    assign dout_b[0] = stim_b[0] & stim_b[1];

    truth_table_sweep #(.ERR_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .loop_en(loop_b),
        .dut_out(dout_b), .stim(stim_b), .busy(busy_b),
        .sample_valid(sv_b), .mismatch(mm_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_vec(fev_b),
        .first_err_valid(fevld_b)
    );

    // Instance C: HOLD=1, 4 inputs, 2 outputs
    logic       start_c, loop_c;
    logic [1:0] flt_c [16];
    logic [1:0] dout_c;
    logic [3:0] stim_c, fev_c;
    logic [7:0] err_c;
    logic       busy_c, sv_c, mm_c, done_c, pass_c, fevld_c;
    always_comb dout_c = (stim_c[1:0] ^ stim_c[3:2]) ^ flt_c[stim_c];

    truth_table_sweep #(
        .N_IN(4), .N_OUT(2), .HOLD(1), .EXPECTED(TBL_C)
    ) u_c (
        .clk(clk), .rst(rst), .start(start_c), .loop_en(loop_c),
        .dut_out(dout_c), .stim(stim_c), .busy(busy_c),
        .sample_valid(sv_c), .mismatch(mm_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .first_err_vec(fev_c),
        .first_err_valid(fevld_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_stim"}, stim_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_sv"}, sv_a, 0);
        chk({tag, "_mm"}, mm_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_pass"}, pass_a, 0);
        chk({tag, "_err"}, err_a, 0);
        chk({tag, "_fev"}, fev_a, 0);
        chk({tag, "_fevld"}, fevld_a, 0);
    endtask

    task automatic run_a(input logic [7:0] resp, input int busy_start_at,
                         input int rst_at, output int cnt, output int first);
        int  v;
        logic m;
        bit  aborted;
        resp_a  = resp;
        cnt     = 0;
        first   = -1;
        aborted = 0;
        m       = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start_a = (k == busy_start_at);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk_idle_a("a_rst_now");
                @(negedge clk);
                chk_idle_a("a_rst_hold");
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (k % 10 == 0) begin
                v = k / 10 - 1;
                m = (resp[v] != maj(v));
                if (m) begin
                    cnt++;
                    if (first < 0) first = v;
                end
            end
            chk("a_stim", stim_a, (k < 80) ? k / 10 : 7);
            chk("a_sv", sv_a, k % 10 == 0);
            if (k % 10 == 0) chk("a_mm", mm_a, m);
            chk("a_err", err_a, cnt);
            chk("a_done", done_a, k == 80);
            chk("a_busy", busy_a, k < 80);
            chk("a_fevld", fevld_a, first >= 0);
            if (first >= 0) chk("a_fev", fev_a, first);
        end
        start_a = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            chk("a_pass", pass_a, cnt == 0);
            chk("a_done_hold", done_a, 1);
            chk("a_stim_hold", stim_a, 7);
            chk("a_err_hold", err_a, cnt);
        end
    endtask

    task automatic run_b();
        int  cnt, first, v;
        logic m;
        cnt    = 0;
        first  = -1;
        m      = 0;
        loop_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            if (k == 250) loop_b = 1'b0;
            if (k % 10 == 0) begin
                v = (k / 10 - 1) % 8;
                m = (((v & 1) & ((v >> 1) & 1)) != maj(v));
                if (m) begin
                    cnt++;
                    if (first < 0) first = v;
                end
            end
            chk("b_stim", stim_b, (k < 320) ? (k / 10) % 8 : 7);
            chk("b_sv", sv_b, k % 10 == 0);
            if (k % 10 == 0) chk("b_mm", mm_b, m);
            chk("b_err", err_b, (cnt > 3) ? 3 : cnt);
            chk("b_done", done_b, k % 80 == 0);
            chk("b_busy", busy_b, k < 320);
            if (first >= 0) chk("b_fev", fev_b, first);
        end
        @(negedge clk);
        chk("b_err_sat", err_b, 3);
        chk("b_fev_final", fev_b, 5);
        chk("b_pass", pass_b, 0);
        chk("b_done_hold", done_b, 1);
    endtask

    task automatic run_c();
        int  cnt, first, v, good, got;
        logic m;
        cnt   = 0;
        first = -1;
        m     = 0;
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            v    = k - 1;
            good = (v % 4) ^ (v / 4);
            got  = good ^ int'(flt_c[v]);
            m    = (got != good);
            if (m) begin
                cnt++;
                if (first < 0) first = v;
            end
            chk("c_stim", stim_c, (k < 16) ? k : 15);
            chk("c_sv", sv_c, 1);
            chk("c_mm", mm_c, m);
            chk("c_err", err_c, cnt);
            chk("c_done", done_c, k == 16);
            chk("c_busy", busy_c, k < 16);
        end
        chk("c_pass", pass_c, cnt == 0);
        chk("c_fevld", fevld_c, first >= 0);
        if (first >= 0) chk("c_fev", fev_c, first);
    endtask

    initial begin
        int cnt, first;
        logic [7:0] mask;
        rst     = 1'b1;
        start_a = 1'b0; loop_a = 1'b0; resp_a = 8'hE8;
        start_b = 1'b0; loop_b = 1'b0;
        start_c = 1'b0; loop_c = 1'b0;
        for (int i = 0; i < 16; i++) flt_c[i] = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk_idle_a("a_reset");
        chk("b_reset_err", err_b, 0);
        chk("c_reset_busy", busy_c, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_a("a_after_reset");

        run_a(8'hE8, -1, -1, cnt, first);
        run_a(8'h88, -1, -1, cnt, first);
        chk("a_and_err", err_a, 2);
        chk("a_and_fev", fev_a, 5);
        chk("a_and_pass", pass_a, 0);

        run_a(8'hE8, 20, -1, cnt, first);
        run_a(8'h88, -1, 35, cnt, first);
        run_a(8'hE8, -1, -1, cnt, first);
        chk("a_fresh_pass", pass_a, 1);

        for (int r = 0; r < 4; r++) begin
            mask = 8'($urandom);
            run_a(8'hE8 ^ mask, -1, -1, cnt, first);
        end

        run_b();

        run_c();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                flt_c[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            end
            run_c();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
